sad_search_ctrl: RTL and testbench
==================================

Name: sad_search_ctrl

Overview:
- Sequences the 16x16 SAD adder-tree datapath over a full-search motion-estimation window.
- Walks every candidate motion vector in raster order and loads each one into the PE array.
- Waits out the datapath pipeline, then captures S16x16 and pulses shift_en_4x4.
- Keeps the running minimum SAD and its motion vector, and reports the best match per macroblock with a start/done handshake.

Parameters:
- SAD_WIDTH, 16, width of the S16x16 input and the best_sad output.
- RANGE, 8, search range; candidate MV components span -RANGE..RANGE-1.
- MV_WIDTH, 5, signed width of the MV outputs; must hold -RANGE..RANGE-1.
- PIPE_LAT, 2, cycles from pe_load to a valid sad_in.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  begin a search; sampled only in IDLE.
- abort  in  1  cancel the search in progress.
- mem_ready  in  1  reference window data available for the current candidate.
- sad_in  in  SAD_WIDTH  S16x16 from the adder tree.
- pe_load  out  1  load the current candidate into the PE array.
- cand_x  out  MV_WIDTH  signed x of the candidate being loaded.
- cand_y  out  MV_WIDTH  signed y of the candidate being loaded.
- shift_en_4x4  out  1  shift enable for the 4x4 partial-SAD delay registers.
- busy  out  1  high from the first LOAD through the last COMPARE.
- done  out  1  one-cycle pulse when the result is valid.
- best_sad  out  SAD_WIDTH  minimum SAD of the last completed search.
- best_mvx  out  MV_WIDTH  signed MV x of best_sad.
- best_mvy  out  MV_WIDTH  signed MV y of best_sad.

Behaviour:
- Reset (reset=0, async): state=IDLE; every output 0; internal counters 0; running minimum all-ones.
- FSM states: IDLE, LOAD, WAIT, COMPARE, DONE.
- IDLE, start=1:
  - cand=(-RANGE,-RANGE).
  - Running minimum = all-ones; running MV = (0,0).
  - Next state LOAD.
- LOAD:
  - pe_load = mem_ready; cand_x/cand_y are driven in this state.
  - mem_ready=0 holds LOAD with no side effects (stall).
  - mem_ready=1 goes to WAIT and clears the wait counter.
- WAIT: counts PIPE_LAT-1 down to 0, then goes to COMPARE. With PIPE_LAT=1, WAIT lasts one cycle.
- COMPARE:
  - shift_en_4x4=1 for exactly this cycle.
  - If sad_in < running minimum (strict), update the minimum and the MV. On a tie the earlier candidate is kept.
  - If cand=(RANGE-1,RANGE-1), go to DONE.
  - Otherwise advance: x+1; at x=RANGE-1, x wraps to -RANGE and y increments. Then go to LOAD.
- DONE:
  - Copy the running minimum and MV to best_sad/best_mvx/best_mvy.
  - done=1 for one cycle; busy=0; next state IDLE.
- Output stability: best_* change only in DONE and hold through later searches until the next DONE.
- Timing with mem_ready held high: one candidate per PIPE_LAT+2 cycles. done is high N*(PIPE_LAT+2)+1 cycles after the edge that samples start, where N=(2*RANGE)^2. Defaults give 1025.
- busy is high in LOAD, WAIT and COMPARE only.
- abort=1 in any non-IDLE state:
  - Next state IDLE; no done pulse; best_* keep the previous completed result.
  - abort has priority over every transition, including DONE→IDLE.
  - If abort is high during DONE, the result still commits, because the outputs update in that cycle.
- start while busy or in DONE is ignored. start and abort together in IDLE: abort wins, so the block stays IDLE.
- Async reset mid-search returns the block to the reset values immediately.
- Arithmetic:
  - The compare is unsigned on SAD_WIDTH.
  - cand_x and cand_y are two's-complement MV_WIDTH values.
  - No saturation; the adder tree owns overflow.

Decomposition:
- Package me_pkg holds:
  - Typedef enum for the FSM states.
  - Typedefs sad_t and mv_t, parameterized by width.
  - Localparam SAD_MAX (all-ones).
- Sub-module sad_min_tracker holds the compare-and-hold of the running minimum:
  - Inputs: clear, en, sad, mvx, mvy.
  - Outputs: min_sad, min_mvx, min_mvy.
- The controller FSM, the candidate counters and the output registers stay in sad_search_ctrl.

Test Plan:
- Flat window: RANGE=2, PIPE_LAT=2, sad_in=100 constant, mem_ready=1, pulse start → done at cycle 65, best_sad=100, MV=(-2,-2) (first candidate wins the tie).
- Unique minimum: defaults; sad_in=500 except 37 when cand=(3,-5) → done at cycle 1025, best_sad=37, best_mvx=3, best_mvy=-5, and exactly 256 shift_en_4x4 pulses.
- Stall: RANGE=2; mem_ready low 3 cycles on every 4th LOAD → pe_load only when mem_ready=1, done at cycle 65+4*3=77, result unchanged from the same data without stalls.
- Abort: first search completes with best_sad=50; second search aborted at candidate 7 → no done pulse, busy falls the next cycle, best_sad stays 50, a new start runs normally.
- Raster wrap: RANGE=2 → cand sequence (-2,-2),(-1,-2),(0,-2),(1,-2),(-2,-1)…(1,1); last candidate last-lowest (sad_in=0 at (1,1)) → MV=(1,1).
- Reset mid-WAIT, plus start while busy: reset=0 → all outputs 0 asynchronously, IDLE after release; start pulses during busy cause no restart, and cand is unchanged.

Source files
------------

// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation search controller.
// Module widths are parameters; sad_t/mv_t describe the default 16-bit SAD / 5-bit MV build.
package me_pkg;

    localparam int SAD_WIDTH_DEF = 16;
    localparam int MV_WIDTH_DEF  = 5;

    typedef logic        [SAD_WIDTH_DEF-1:0] sad_t;
    typedef logic signed [MV_WIDTH_DEF-1:0]  mv_t;

    localparam sad_t SAD_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_COMPARE,
        ST_DONE
    } state_t;

    // A one-cycle pipeline still needs a 1-bit counter so the WAIT logic stays uniform.
    function automatic int wait_cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/sad_min_tracker.sv
// Running minimum of candidate SADs with the motion vector that produced it.
// Strict less-than on the unsigned SAD keeps the earliest candidate on a tie.
module sad_min_tracker
    import me_pkg::*;
#(
    parameter int SAD_WIDTH = 16,
    parameter int MV_WIDTH  = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        en,
    input  logic        [SAD_WIDTH-1:0] sad,
    input  logic signed [MV_WIDTH-1:0]  mvx,
    input  logic signed [MV_WIDTH-1:0]  mvy,
    output logic        [SAD_WIDTH-1:0] min_sad,
    output logic signed [MV_WIDTH-1:0]  min_mvx,
    output logic signed [MV_WIDTH-1:0]  min_mvy
);

    logic        [SAD_WIDTH-1:0] r_min_sad;
    logic signed [MV_WIDTH-1:0]  r_min_mvx;
    logic signed [MV_WIDTH-1:0]  r_min_mvy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_min_sad <= '1;
            r_min_mvx <= '0;
            r_min_mvy <= '0;
        end else if (clear) begin
            r_min_sad <= '1;
            r_min_mvx <= '0;
            r_min_mvy <= '0;
        end else if (en && (sad < r_min_sad)) begin
            r_min_sad <= sad;
            r_min_mvx <= mvx;
            r_min_mvy <= mvy;
        end
    end

    assign min_sad = r_min_sad;
    assign min_mvx = r_min_mvx;
    assign min_mvy = r_min_mvy;

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search controller: walks every candidate MV in raster order, waits out the
// adder-tree pipeline, tracks the minimum SAD and reports it with a done pulse.
module sad_search_ctrl
    import me_pkg::*;
#(
    parameter int SAD_WIDTH = 16,
    parameter int RANGE     = 8,
    parameter int MV_WIDTH  = 5,
    parameter int PIPE_LAT  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        mem_ready,
    input  logic        [SAD_WIDTH-1:0] sad_in,
    output logic                        pe_load,
    output logic signed [MV_WIDTH-1:0]  cand_x,
    output logic signed [MV_WIDTH-1:0]  cand_y,
    output logic                        shift_en_4x4,
    output logic                        busy,
    output logic                        done,
    output logic        [SAD_WIDTH-1:0] best_sad,
    output logic signed [MV_WIDTH-1:0]  best_mvx,
    output logic signed [MV_WIDTH-1:0]  best_mvy
);

    localparam int WAIT_W = wait_cnt_width(PIPE_LAT);
    localparam logic signed [MV_WIDTH-1:0] MV_LO = MV_WIDTH'(-RANGE);
    localparam logic signed [MV_WIDTH-1:0] MV_HI = MV_WIDTH'(RANGE - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PIPE_LAT - 1);

    state_t r_state;
    state_t w_next_state;

    logic        [WAIT_W-1:0]    r_wait;
    logic signed [MV_WIDTH-1:0]  r_cand_x;
    logic signed [MV_WIDTH-1:0]  r_cand_y;
    logic        [SAD_WIDTH-1:0] r_best_sad;
    logic signed [MV_WIDTH-1:0]  r_best_mvx;
    logic signed [MV_WIDTH-1:0]  r_best_mvy;
    logic                        r_done;

    logic                        w_start_ok;
    logic                        w_last_cand;
    logic                        w_wait_done;
    logic                        w_pe_load;
    logic                        w_shift_en;
    logic                        w_busy;
    logic        [SAD_WIDTH-1:0] w_min_sad;
    logic signed [MV_WIDTH-1:0]  w_min_mvx;
    logic signed [MV_WIDTH-1:0]  w_min_mvy;

    assign w_start_ok  = start && !abort;
    assign w_last_cand = (r_cand_x == MV_HI) && (r_cand_y == MV_HI);
    assign w_wait_done = (r_wait == WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // abort outranks every transition; DONE always falls back to IDLE anyway.
    always_comb begin
        w_next_state = r_state;
        w_pe_load    = 1'b0;
        w_shift_en   = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_busy = 1'b1;
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (mem_ready) begin
                    w_pe_load    = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_wait_done) begin
                    w_next_state = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                w_busy     = 1'b1;
                w_shift_en = 1'b1;
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_last_cand) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Candidate counters, pipeline wait counter and the committed result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait     <= '0;
            r_cand_x   <= '0;
            r_cand_y   <= '0;
            r_best_sad <= '0;
            r_best_mvx <= '0;
            r_best_mvy <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE) && !abort;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_cand_x <= MV_LO;
                        r_cand_y <= MV_LO;
                    end
                end
                ST_LOAD: begin
                    if (mem_ready) begin
                        r_wait <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!w_wait_done) begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ST_COMPARE: begin
                    if (!abort && !w_last_cand) begin
                        if (r_cand_x == MV_HI) begin
                            r_cand_x <= MV_LO;
                            r_cand_y <= r_cand_y + MV_WIDTH'(1);
                        end else begin
                            r_cand_x <= r_cand_x + MV_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Commits even when abort is high in this cycle.
                    r_best_sad <= w_min_sad;
                    r_best_mvx <= w_min_mvx;
                    r_best_mvy <= w_min_mvy;
                end
                default: begin
                end
            endcase
        end
    end

    sad_min_tracker #(
        .SAD_WIDTH (SAD_WIDTH),
        .MV_WIDTH  (MV_WIDTH)
    ) u_min_tracker (
        .clk     (clk),
        .reset   (reset),
        .clear   ((r_state == ST_IDLE) && w_start_ok),
        .en      (w_shift_en),
        .sad     (sad_in),
        .mvx     (r_cand_x),
        .mvy     (r_cand_y),
        .min_sad (w_min_sad),
        .min_mvx (w_min_mvx),
        .min_mvy (w_min_mvy)
    );

    assign pe_load      = w_pe_load;
    assign shift_en_4x4 = w_shift_en;
    assign busy         = w_busy;
    assign cand_x       = r_cand_x;
    assign cand_y       = r_cand_y;
    assign done         = r_done;
    assign best_sad     = r_best_sad;
    assign best_mvx     = r_best_mvx;
    assign best_mvy     = r_best_mvy;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl: a RANGE=2 instance for the table and corner
// sequences, and a default-parameter instance for the full 16x16 window.
module tb_sad_search_ctrl;

    localparam int PAT_FLAT  = 0;
    localparam int PAT_POINT = 1;
    localparam int PAT_TWO   = 2;
    localparam int PAT_DESC  = 3;

    typedef struct {
        int pat;
        int base;
        int pv;
        int px;
        int py;
        bit stall;
        int expCyc;
        int expSad;
        int expMx;
        int expMy;
    } vec_t;

    logic clk = 1'b0;
    logic rstN;

    logic               start2, abort2;
    logic               memReady2 = 1'b1;
    logic        [15:0] sad2;
    logic               peLoad2, shift2, busy2, done2;
    logic signed [4:0]  candX2, candY2, bestMx2, bestMy2;
    logic        [15:0] bestSad2;

    logic               startD, abortD, memReadyD;
    logic        [15:0] sadD;
    logic               peLoadD, shiftD, busyD, doneD;
    logic signed [4:0]  candXD, candYD, bestMxD, bestMyD;
    logic        [15:0] bestSadD;

    int patKind, patBase, patVal, patX, patY;
    bit stallOn;
    int cx2, cy2, idx2;
    int nCompared = 0;
    int nMismatched = 0;
    int peTotal2 = 0, shiftTotal2 = 0, peNoReady2 = 0, peTotalD = 0, shiftTotalD = 0;
    int logX[$];
    int logY[$];
    int lowCnt = 0, prevIdx = -1;
    vec_t vecs[8];

    always #5 clk = ~clk;

    sad_search_ctrl #(.SAD_WIDTH(16), .RANGE(2), .MV_WIDTH(5), .PIPE_LAT(2)) dut2 (
        .clk(clk), .reset(rstN), .start(start2), .abort(abort2), .mem_ready(memReady2),
        .sad_in(sad2), .pe_load(peLoad2), .cand_x(candX2), .cand_y(candY2),
        .shift_en_4x4(shift2), .busy(busy2), .done(done2), .best_sad(bestSad2),
        .best_mvx(bestMx2), .best_mvy(bestMy2)
    );

    sad_search_ctrl dutD (
        .clk(clk), .reset(rstN), .start(startD), .abort(abortD), .mem_ready(memReadyD),
        .sad_in(sadD), .pe_load(peLoadD), .cand_x(candXD), .cand_y(candYD),
        .shift_en_4x4(shiftD), .busy(busyD), .done(doneD), .best_sad(bestSadD),
        .best_mvx(bestMxD), .best_mvy(bestMyD)
    );

    // Stand-in for the adder tree on the small instance: the SAD is a function of
    // whichever candidate is currently loaded, shaped by the active pattern.
    always_comb begin
        cx2  = int'(candX2);
        cy2  = int'(candY2);
        idx2 = (cy2 + 2) * 4 + (cx2 + 2);
        sad2 = 16'(patBase);
        case (patKind)
            PAT_POINT: if (cx2 == patX && cy2 == patY) sad2 = 16'(patVal);
            PAT_TWO:   if ((cx2 == patX && cy2 == patY) || (cx2 == -2 && cy2 == 1)) sad2 = 16'(patVal);
            PAT_DESC:  sad2 = 16'(patBase - idx2);
            default: ;
        endcase
    end

    // The big window has one unique minimum of 37 at (3,-5) in a field of 500.
    always_comb begin
        sadD = (int'(candXD) == 3 && int'(candYD) == -5) ? 16'd37 : 16'd500;
    end

    // Memory-stall model: every 4th candidate in raster order sees mem_ready low
    // for its first three busy cycles, which all fall inside that candidate's LOAD.
    always @(posedge clk) begin
        #1;
        if (idx2 != prevIdx) begin
            lowCnt  = 0;
            prevIdx = idx2;
        end
        if (stallOn && (idx2 % 4 == 3) && lowCnt < 3) begin
            memReady2 = 1'b0;
            if (busy2) lowCnt++;
        end else begin
            memReady2 = 1'b1;
        end
    end

    // Running tallies of loads and shift pulses, plus the order candidates were loaded in.
    always @(negedge clk) begin
        if (peLoad2) begin
            peTotal2++;
            if (!memReady2) peNoReady2++;
            logX.push_back(cx2);
            logY.push_back(cy2);
        end
        if (shift2)  shiftTotal2++;
        if (peLoadD) peTotalD++;
        if (shiftD)  shiftTotalD++;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setPattern(input int kind, input int base, input int pv,
                              input int px, input int py, input bit stall);
        patKind = kind;
        patBase = base;
        patVal  = pv;
        patX    = px;
        patY    = py;
        stallOn = stall;
    endtask

    // Runs one complete search on the RANGE=2 instance and checks latency and result.
    task automatic applyStimulus(input string tag, input vec_t v);
        int cyc;
        int pe0, sh0, nr0;
        bit seen;
        setPattern(v.pat, v.base, v.pv, v.px, v.py, v.stall);
        pe0 = peTotal2;
        sh0 = shiftTotal2;
        nr0 = peNoReady2;
        logX.delete();
        logY.delete();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 2000) begin
            tick();
            cyc++;
            if (done2) seen = 1'b1;
        end
        checkOutput({tag, "_done_cycle"}, seen ? cyc : -1, v.expCyc);
        checkOutput({tag, "_best_sad"}, int'(bestSad2), v.expSad);
        checkOutput({tag, "_best_mvx"}, int'(bestMx2), v.expMx);
        checkOutput({tag, "_best_mvy"}, int'(bestMy2), v.expMy);
        checkOutput({tag, "_pe_loads"}, peTotal2 - pe0, 16);
        checkOutput({tag, "_shift_pulses"}, shiftTotal2 - sh0, 16);
        checkOutput({tag, "_load_without_ready"}, peNoReady2 - nr0, 0);
        tick();
        checkOutput({tag, "_done_one_cycle"}, int'(done2), 0);
    endtask

    initial begin
        int cyc, doneCnt, savedX, savedY, k;
        bit seen;
        vec_t v;

        vecs[0] = '{PAT_FLAT,  100,   0,  0,  0, 1'b0, 65, 100,   -2, -2};
        vecs[1] = '{PAT_POINT, 300,   0,  1,  1, 1'b0, 65, 0,      1,  1};
        vecs[2] = '{PAT_TWO,   90,   20,  1, -1, 1'b0, 65, 20,     1, -1};
        vecs[3] = '{PAT_DESC,  200,   0,  0,  0, 1'b0, 65, 185,    1,  1};
        vecs[4] = '{PAT_FLAT,  65535, 0,  0,  0, 1'b0, 65, 65535,  0,  0};
        vecs[5] = '{PAT_FLAT,  100,   0,  0,  0, 1'b1, 77, 100,   -2, -2};
        vecs[6] = '{PAT_POINT, 100,   7,  0, -1, 1'b1, 77, 7,      0, -1};
        vecs[7] = '{PAT_POINT, 100,   7,  0, -1, 1'b0, 65, 7,      0, -1};

        rstN = 1'b0;
        start2 = 1'b0; abort2 = 1'b0;
        startD = 1'b0; abortD = 1'b0; memReadyD = 1'b1;
        setPattern(PAT_FLAT, 100, 0, 0, 0, 1'b0);

        repeat (2) tick();
        checkOutput("rst_busy", int'(busy2), 0);
        checkOutput("rst_done", int'(done2), 0);
        checkOutput("rst_pe_load", int'(peLoad2), 0);
        checkOutput("rst_shift", int'(shift2), 0);
        checkOutput("rst_cand_x", int'(candX2), 0);
        checkOutput("rst_cand_y", int'(candY2), 0);
        checkOutput("rst_best_sad", int'(bestSad2), 0);
        checkOutput("rst_best_mv", int'(bestMx2) * 100 + int'(bestMy2), 0);
        checkOutput("rst_dflt_busy", int'(busyD), 0);
        @(negedge clk);
        rstN = 1'b1;
        tick();

        // Table of complete searches; the first one also checks raster order.
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            applyStimulus($sformatf("vec%0d", i), v);
            if (i == 0) begin
                k = 0;
                for (int y = -2; y <= 1; y++) begin
                    for (int x = -2; x <= 1; x++) begin
                        checkOutput($sformatf("raster%0d_x", k), (k < logX.size()) ? logX[k] : 99, x);
                        checkOutput($sformatf("raster%0d_y", k), (k < logY.size()) ? logY[k] : 99, y);
                        k++;
                    end
                end
            end
        end

        // Full default window: 256 candidates, unique minimum at (3,-5).
        begin
            int pe0, sh0;
            pe0 = peTotalD;
            sh0 = shiftTotalD;
            startD = 1'b1;
            tick();
            startD = 1'b0;
            seen = 1'b0;
            cyc = 0;
            while (!seen && cyc < 5000) begin
                tick();
                cyc++;
                if (doneD) seen = 1'b1;
            end
            checkOutput("dflt_done_cycle", seen ? cyc : -1, 1025);
            checkOutput("dflt_best_sad", int'(bestSadD), 37);
            checkOutput("dflt_best_mvx", int'(bestMxD), 3);
            checkOutput("dflt_best_mvy", int'(bestMyD), -5);
            checkOutput("dflt_shift_pulses", shiftTotalD - sh0, 256);
            checkOutput("dflt_pe_loads", peTotalD - pe0, 256);
        end

        // Abort mid-search leaves the last completed result in place.
        v = '{PAT_FLAT, 50, 0, 0, 0, 1'b0, 65, 50, -2, -2};
        applyStimulus("abort_pre", v);
        setPattern(PAT_FLAT, 10, 0, 0, 0, 1'b0);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (k = 0; k < 200 && !(idx2 == 7 && busy2); k++) tick();
        checkOutput("abort_reached_cand7", idx2, 7);
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        checkOutput("abort_busy_falls", int'(busy2), 0);
        doneCnt = 0;
        for (int j = 0; j < 80; j++) begin
            if (done2) doneCnt++;
            tick();
        end
        checkOutput("abort_no_done", doneCnt, 0);
        checkOutput("abort_best_sad_kept", int'(bestSad2), 50);

        // start and abort together in IDLE: abort wins.
        start2 = 1'b1;
        abort2 = 1'b1;
        tick();
        start2 = 1'b0;
        abort2 = 1'b0;
        checkOutput("start_abort_idle_busy", int'(busy2), 0);
        tick();
        checkOutput("start_abort_idle_busy2", int'(busy2), 0);

        v = '{PAT_FLAT, 60, 0, 0, 0, 1'b0, 65, 60, -2, -2};
        applyStimulus("after_abort", v);

        // abort while in DONE: the result commits but no done pulse.
        setPattern(PAT_POINT, 70, 9, 1, 0, 1'b0);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (64) tick();
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        checkOutput("abort_in_done_no_pulse", int'(done2), 0);
        checkOutput("abort_in_done_best_sad", int'(bestSad2), 9);
        checkOutput("abort_in_done_best_mvx", int'(bestMx2), 1);
        checkOutput("abort_in_done_busy", int'(busy2), 0);
        tick();
        checkOutput("abort_in_done_no_late_pulse", int'(done2), 0);

        // start pulses during busy are ignored and do not disturb the walk.
        setPattern(PAT_FLAT, 80, 0, 0, 0, 1'b0);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (10) tick();
        savedX = cx2;
        savedY = cy2;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        checkOutput("busy_start_cand_x", cx2, savedX);
        checkOutput("busy_start_cand_y", cy2, savedY);
        checkOutput("busy_start_still_busy", int'(busy2), 1);
        seen = 1'b0;
        cyc = 11;
        while (!seen && cyc < 2000) begin
            tick();
            cyc++;
            if (done2) seen = 1'b1;
        end
        checkOutput("busy_start_done_cycle", seen ? cyc : -1, 65);
        checkOutput("busy_start_best_sad", int'(bestSad2), 80);

        // Asynchronous reset in the middle of WAIT.
        setPattern(PAT_FLAT, 40, 0, 0, 0, 1'b0);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (6) tick();
        rstN = 1'b0;
        #1;
        checkOutput("midrst_busy", int'(busy2), 0);
        checkOutput("midrst_done", int'(done2), 0);
        checkOutput("midrst_cand_x", int'(candX2), 0);
        checkOutput("midrst_cand_y", int'(candY2), 0);
        checkOutput("midrst_best_sad", int'(bestSad2), 0);
        checkOutput("midrst_shift", int'(shift2), 0);
        @(negedge clk);
        rstN = 1'b1;
        tick();
        checkOutput("midrst_idle_busy", int'(busy2), 0);
        tick();
        checkOutput("midrst_idle_busy2", int'(busy2), 0);
        v = '{PAT_POINT, 100, 3, -1, 0, 1'b0, 65, 3, -1, 0};
        applyStimulus("after_reset", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
